rf_write_arbiter: RTL
=====================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter CNT_W, default 16, commit counter width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports req0_valid/req1_valid  input  1 each  write request from source 0 (ALU) and source 1 (load unit).
REQ-007 SHALL have ports req0_addr/req1_addr  input  ADDR_W each  destination register.
REQ-008 SHALL have ports req0_data/req1_data  input  DATA_W each  write data.
REQ-009 SHALL have ports req0_ready/req1_ready  output  1 each  request accepted this cycle.
REQ-010 SHALL have ports alloc_valid  input  1 and alloc_addr  input  ADDR_W  issue-time reservation of a destination register.
REQ-011 SHALL have ports q1_addr/q2_addr  input  ADDR_W each and q1_busy/q2_busy  output  1 each  pending-write query.
REQ-012 SHALL have ports rf_we  output  1, rf_wa  output  ADDR_W, rf_wd  output  DATA_W  register-file write port drive.
REQ-013 SHALL have port commit_cnt  output  CNT_W  number of committed register writes.

Function
REQ-014 SHALL transfer a request when reqN_valid and reqN_ready are both high at a rising edge.
REQ-015 SHALL assert at most one of req0_ready/req1_ready per cycle; readies are combinational from valids and the grant pointer.
REQ-016 SHALL, with one valid request, assert that requester's ready in the same cycle.
REQ-017 SHALL, with both valid, grant the requester not granted on the most recent transfer (round-robin).
REQ-018 SHALL update the grant pointer only on a transfer; idle cycles leave it unchanged.
REQ-019 SHALL drive rf_we/rf_wa/rf_wd from registers, one cycle after the transfer edge (latency 1).
REQ-020 SHALL deassert rf_we in any cycle following no transfer; rf_wa/rf_wd hold their last values.
REQ-021 SHALL accept a request with addr 0 (ready high) but produce rf_we=0, no commit count, no scoreboard change.
REQ-022 SHALL keep a pending mask of 2**ADDR_W bits; bit 0 is always 0.
REQ-023 SHALL set pending[alloc_addr] on alloc_valid with alloc_addr != 0.
REQ-024 SHALL clear pending[a] at the edge on which rf_we is asserted with rf_wa = a.
REQ-025 SHALL, on simultaneous set and clear of the same bit, leave it set (newer producer wins).
REQ-026 SHALL drive qN_busy = pending[qN_addr] combinationally; address 0 always reports 0.
REQ-027 SHALL increment commit_cnt once per cycle in which rf_we is high, saturating at all-ones.
REQ-028 SHALL not require or check that a committed address was allocated; unallocated commits only count.

Reset
REQ-029 SHALL, when reset is high at a rising edge, clear rf_we, rf_wa, rf_wd, pending mask and commit_cnt to 0.
REQ-030 SHALL set the grant pointer on reset so source 0 wins the first contended cycle.
REQ-031 SHALL drive req0_ready and req1_ready low while reset is high; no transfer occurs.
REQ-032 SHALL discard on reset any request registered in the output stage (rf_we low next cycle).

Verification
REQ-033 Reset then req0 valid addr 5 data 0xDEADBEEF alone -> req0_ready=1 that cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; commit_cnt=1.
REQ-034 Both valid for 4 cycles (addr 1/2) -> grants 0,1,0,1; rf_wa sequence 1,2,1,2 one cycle delayed.
REQ-035 alloc addr 7, then q1_addr=7 -> q1_busy=1; req1 writes 7 -> q1_busy=0 the cycle after rf_we.
REQ-036 alloc addr 9 same edge as rf_we commit to 9 -> q1_busy(9) remains 1.
REQ-037 req0 addr 0 data 0x1 -> req0_ready=1, rf_we stays 0, commit_cnt unchanged.
REQ-038 Reset asserted the edge after a transfer -> rf_we=0, pending=0, commit_cnt=0, next contended grant to source 0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for two register-file write sources, with a per-register pending-write scoreboard and a commit counter.
// The RF write port is registered (latency 1). Readies are combinational, and a losing requester is held off until it wins a later cycle.
module rf_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic [ADDR_W-1:0] q1_addr,
    input  logic [ADDR_W-1:0] q2_addr,
    output logic              q1_busy,
    output logic              q2_busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [CNT_W-1:0]  commit_cnt
);
    localparam int NREG = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t             req0_wr;
    wr_t             req1_wr;
    wr_t             win_wr;
    logic            last_grant;   // 1 when source 1 won the most recent transfer
    logic            grant0;
    logic            grant1;
    logic            xfer;
    logic            commit;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_set;
    logic [NREG-1:0] pending_clr;

    assign req0_wr = '{addr: req0_addr, data: req0_data};
    assign req1_wr = '{addr: req1_addr, data: req1_data};

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;
    assign win_wr     = grant1 ? req1_wr : req0_wr;
    // Writes to register 0 are accepted but dropped here.
    assign commit     = xfer && (win_wr.addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
        end else begin
            if (xfer) begin
                last_grant <= grant1;
            end
            rf_we <= commit;
            if (commit) begin
                rf_wa <= win_wr.addr;
                rf_wd <= win_wr.data;
            end
        end
    end

    // Set is applied after clear so a fresh allocation survives a same-edge commit.
    always_comb begin
        pending_set = '0;
        pending_clr = '0;
        if (alloc_valid) begin
            pending_set[alloc_addr] = 1'b1;
        end
        if (rf_we) begin
            pending_clr[rf_wa] = 1'b1;
        end
        pending_set[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pending_clr) | pending_set;
        end
    end

    assign q1_busy = (q1_addr != '0) && pending[q1_addr];
    assign q2_busy = (q2_addr != '0) && pending[q2_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_cnt <= '0;
        end else if (rf_we && (commit_cnt != '1)) begin
            commit_cnt <= commit_cnt + CNT_W'(1);
        end
    end
endmodule
